sim_ctrl_monitor: RTL and testbench

- Synthesisable simulation-control block for multi-hart core testbenches.
- Sequences core reset release, the firmware-load request and fetch enable.
- Monitors per-hart pass/fail/exit signals plus a cycle watchdog, and latches one sticky verdict with the source hart and exit code.
- Sits between the bench clock/reset generators and the core wrapper(s); the bench prints and finishes only on done_o.

---
 rtl/sim_ctrl_monitor.sv | 187 ++++++++++++++++++
 tb/tb_sim_ctrl_monitor.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sim_ctrl_monitor.sv
// Simulation-control block: sequences core reset, firmware load and fetch enable,
// then watches per-hart pass/fail/exit flags and a watchdog to latch one sticky verdict.
module sim_ctrl_monitor #(
   parameter int unsigned NUM_HARTS            = 1,
   parameter int unsigned RESET_WAIT_CYCLES    = 4,
   parameter int unsigned FIRMWARE_WAIT_CYCLES = 6,
   parameter int unsigned CNT_WIDTH            = 32,
   parameter int unsigned EXIT_WIDTH           = 32,
   localparam int unsigned HART_W = (NUM_HARTS > 1) ? $clog2(NUM_HARTS) : 1
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            load_done_i,
   input  logic [NUM_HARTS-1:0]            tests_passed_i,
   input  logic [NUM_HARTS-1:0]            tests_failed_i,
   input  logic [NUM_HARTS-1:0]            exit_valid_i,
   input  logic [NUM_HARTS*EXIT_WIDTH-1:0] exit_value_i,
   input  logic [CNT_WIDTH-1:0]            max_cycles_i,
   output logic                            core_rst_no,
   output logic                            load_req_o,
   output logic                            fetch_enable_o,
   output logic                            done_o,
   output logic [2:0]                      status_o,
   output logic [HART_W-1:0]               done_hart_o,
   output logic [EXIT_WIDTH-1:0]           exit_code_o,
   output logic [CNT_WIDTH-1:0]            cycle_cnt_o
);

   typedef enum logic [2:0] {
      ST_RST_HOLD  = 3'd0,
      ST_LOAD_REQ  = 3'd1,
      ST_LOAD_WAIT = 3'd2,
      ST_RUN       = 3'd3,
      ST_DONE      = 3'd4
   } state_e;

   typedef enum logic [2:0] {
      STAT_NONE     = 3'd0,
      STAT_PASS     = 3'd1,
      STAT_FAIL     = 3'd2,
      STAT_EXIT_OK  = 3'd3,
      STAT_EXIT_ERR = 3'd4,
      STAT_TIMEOUT  = 3'd5
   } status_e;

   // The sequence counter only has to reach FIRMWARE_WAIT_CYCLES; it saturates above that.
   localparam int unsigned       SEQ_W   = $clog2(FIRMWARE_WAIT_CYCLES + 2);
   localparam logic [SEQ_W-1:0]  SEQ_MAX = '1;
   localparam logic [SEQ_W-1:0]  RST_AT  = SEQ_W'(RESET_WAIT_CYCLES);
   localparam logic [SEQ_W-1:0]  LOAD_AT = SEQ_W'(FIRMWARE_WAIT_CYCLES - 1);
   localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

   state_e                 state_q, state_d;
   logic [SEQ_W-1:0]       seq_q, seq_d;
   logic                   core_rst_q, core_rst_d;
   logic                   load_req_q, load_req_d;
   logic                   fetch_q, fetch_d;
   logic                   done_q, done_d;
   status_e                status_q, status_d;
   logic [HART_W-1:0]      hart_q, hart_d;
   logic [EXIT_WIDTH-1:0]  code_q, code_d;
   logic [CNT_WIDTH-1:0]   cyc_q, cyc_d;

   logic                   ev_found;
   status_e                ev_status;
   logic [HART_W-1:0]      ev_hart;
   logic [EXIT_WIDTH-1:0]  ev_code;
   logic                   wd_fire;
   logic                   verdict;

   // Lowest-index hart with any flag wins; within a hart, failed > passed > exit.
   always_comb begin
      // NOTE: every combinational output gets a default first so no latch is inferred.
      ev_found  = 1'b0;
      ev_status = STAT_NONE;
      ev_hart   = '0;
      ev_code   = '0;
      for (int h = 0; h < int'(NUM_HARTS); h++) begin
         if (!ev_found && (tests_failed_i[h] || tests_passed_i[h] || exit_valid_i[h])) begin
            ev_found = 1'b1;
            ev_hart  = HART_W'(h);
            if (tests_failed_i[h]) begin
               ev_status = STAT_FAIL;
            end else if (tests_passed_i[h]) begin
               ev_status = STAT_PASS;
            end else begin
               ev_code   = exit_value_i[h*EXIT_WIDTH +: EXIT_WIDTH];
               ev_status = (ev_code == '0) ? STAT_EXIT_OK : STAT_EXIT_ERR;
            end
         end
      end
   end

   assign wd_fire = (max_cycles_i != '0) && (cyc_q >= max_cycles_i);
   assign verdict = (state_q == ST_RUN) && (ev_found || wd_fire);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_RST_HOLD;
      end else begin
         // NOTE: sequential state is updated with non-blocking assignments only.
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_RST_HOLD:  if (seq_q >= LOAD_AT) state_d = ST_LOAD_REQ;
         ST_LOAD_REQ:  state_d = ST_LOAD_WAIT;
         ST_LOAD_WAIT: if (load_done_i) state_d = ST_RUN;
         ST_RUN:       if (ev_found || wd_fire) state_d = ST_DONE;
         ST_DONE:      state_d = ST_DONE;
         default:      state_d = ST_RST_HOLD;
      endcase
   end

   // Output process: computes the next value of every registered output.
   always_comb begin
      seq_d      = seq_q;
      core_rst_d = core_rst_q;
      load_req_d = (state_q == ST_LOAD_REQ);
      fetch_d    = fetch_q;
      done_d     = done_q;
      status_d   = status_q;
      hart_d     = hart_q;
      code_d     = code_q;
      cyc_d      = cyc_q;

      if ((state_q == ST_RST_HOLD || state_q == ST_LOAD_REQ || state_q == ST_LOAD_WAIT)
          && seq_q != SEQ_MAX) begin
         seq_d = seq_q + 1'b1;
      end
      if (seq_q >= RST_AT) begin
         core_rst_d = 1'b1;
      end
      if (state_q == ST_LOAD_WAIT && load_done_i) begin
         fetch_d = 1'b1;
      end

      if (state_q == ST_RUN) begin
         if (verdict) begin
            fetch_d  = 1'b0;
            done_d   = 1'b1;
            status_d = ev_found ? ev_status : STAT_TIMEOUT;
            hart_d   = ev_found ? ev_hart : '0;
            code_d   = ev_found ? ev_code : '0;
         end else if (cyc_q != CNT_MAX) begin
            cyc_d = cyc_q + CNT_WIDTH'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seq_q      <= '0;
         core_rst_q <= 1'b0;
         load_req_q <= 1'b0;
         fetch_q    <= 1'b0;
         done_q     <= 1'b0;
         status_q   <= STAT_NONE;
         hart_q     <= '0;
         code_q     <= '0;
         cyc_q      <= '0;
      end else begin
         seq_q      <= seq_d;
         core_rst_q <= core_rst_d;
         load_req_q <= load_req_d;
         fetch_q    <= fetch_d;
         done_q     <= done_d;
         status_q   <= status_d;
         hart_q     <= hart_d;
         code_q     <= code_d;
         cyc_q      <= cyc_d;
      end
   end

   assign core_rst_no    = core_rst_q;
   assign load_req_o     = load_req_q;
   assign fetch_enable_o = fetch_q;
   assign done_o         = done_q;
   assign status_o       = status_q;
   assign done_hart_o    = hart_q;
   assign exit_code_o    = code_q;
   assign cycle_cnt_o    = cyc_q;

endmodule

// File: tb/tb_sim_ctrl_monitor.sv
// Bench for sim_ctrl_monitor (4 harts): directed scenarios plus randomized episodes
// checked against a cycle-level reference model derived from the sequencing and verdict rules.
module tb_sim_ctrl_monitor;

   localparam int NH = 4;
   localparam int R  = 4;
   localparam int F  = 6;
   localparam int CW = 32;
   localparam int EW = 32;
   localparam int HW = 2;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              load_done_i = 1'b0;
   logic [NH-1:0]     tests_passed_i = '0;
   logic [NH-1:0]     tests_failed_i = '0;
   logic [NH-1:0]     exit_valid_i = '0;
   logic [NH*EW-1:0]  exit_value_i = '0;
   logic [CW-1:0]     max_cycles_i = '0;
   logic              core_rst_no, load_req_o, fetch_enable_o, done_o;
   logic [2:0]        status_o;
   logic [HW-1:0]     done_hart_o;
   logic [EW-1:0]     exit_code_o;
   logic [CW-1:0]     cycle_cnt_o;

   sim_ctrl_monitor #(
      .NUM_HARTS(NH), .RESET_WAIT_CYCLES(R), .FIRMWARE_WAIT_CYCLES(F),
      .CNT_WIDTH(CW), .EXIT_WIDTH(EW)
   ) dut (
      .clk(clk), .rst_n(rst_n), .load_done_i(load_done_i),
      .tests_passed_i(tests_passed_i), .tests_failed_i(tests_failed_i),
      .exit_valid_i(exit_valid_i), .exit_value_i(exit_value_i),
      .max_cycles_i(max_cycles_i), .core_rst_no(core_rst_no), .load_req_o(load_req_o),
      .fetch_enable_o(fetch_enable_o), .done_o(done_o), .status_o(status_o),
      .done_hart_o(done_hart_o), .exit_code_o(exit_code_o), .cycle_cnt_o(cycle_cnt_o)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Reference model: edges since release, run/done flags and the latched verdict.
   int          k;
   bit          m_run, m_done;
   logic [63:0] m_cyc;
   int          m_status, m_hart;
   logic [63:0] m_code;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      k = 0; m_run = 0; m_done = 0; m_cyc = 0; m_status = 0; m_hart = 0; m_code = 0;
   endtask

   task automatic model_edge();
      int          st;
      int          hh;
      logic [63:0] cc;
      if (rst_n) begin
         k++;
         if (!m_run) begin
            if (k >= F + 2 && load_done_i) m_run = 1;
         end else if (!m_done) begin
            st = 0; hh = 0; cc = 0;
            for (int h = 0; h < NH; h++) begin
               if (st == 0) begin
                  if (tests_failed_i[h]) begin
                     st = 2; hh = h;
                  end else if (tests_passed_i[h]) begin
                     st = 1; hh = h;
                  end else if (exit_valid_i[h]) begin
                     cc = 64'(exit_value_i[h*EW +: EW]);
                     st = (cc == 0) ? 3 : 4; hh = h;
                  end
               end
            end
            if (st == 0 && max_cycles_i != 0 && m_cyc >= 64'(max_cycles_i)) st = 5;
            if (st != 0) begin
               m_done = 1; m_status = st; m_hart = hh; m_code = cc;
            end else if (m_cyc < 64'hFFFF_FFFF) begin
               m_cyc++;
            end
         end
      end
   endtask

   task automatic compare_all(input string ph);
      check({ph, ".core_rst_no"}, 64'(core_rst_no), 64'(k >= R + 1));
      check({ph, ".load_req"},    64'(load_req_o),  64'(k == F + 1));
      check({ph, ".fetch"},       64'(fetch_enable_o), 64'(m_run && !m_done));
      check({ph, ".done"},        64'(done_o),      64'(m_done));
      check({ph, ".status"},      64'(status_o),    64'(m_status));
      check({ph, ".hart"},        64'(done_hart_o), 64'(m_hart));
      check({ph, ".code"},        64'(exit_code_o), m_code);
      check({ph, ".cycles"},      64'(cycle_cnt_o), m_cyc);
   endtask

   task automatic cycle();
      @(posedge clk);
      model_edge();
      #1;
      compare_all("cyc");
   endtask

   task automatic clear_ev();
      tests_passed_i = '0; tests_failed_i = '0; exit_valid_i = '0; exit_value_i = '0;
   endtask

   task automatic set_exit(input int h, input logic [EW-1:0] v);
      exit_valid_i[h] = 1'b1;
      exit_value_i[h*EW +: EW] = v;
   endtask

   // Assert reset mid-cycle (outputs must clear at once), hold two edges, then release.
   task automatic do_reset();
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      compare_all("rst");
      clear_ev();
      load_done_i = 1'b0;
      cycle();
      cycle();
      rst_n = 1'b1;
   endtask

   task automatic to_run();
      for (int n = 0; n < 40 && !m_run; n++) cycle();
      check("run_entry", 64'(fetch_enable_o), 64'd1);
   endtask

   task automatic rand_ev();
      tests_failed_i = NH'($urandom) & NH'($urandom) & NH'($urandom);
      tests_passed_i = NH'($urandom) & NH'($urandom);
      exit_valid_i   = NH'($urandom);
      for (int h = 0; h < NH; h++)
         exit_value_i[h*EW +: EW] = ($urandom_range(0, 1) == 0) ? '0 : EW'($urandom_range(1, 15));
   endtask

   initial begin
      int first_rst, first_req, req_cnt, first_fetch, ld_delay;
      @(posedge clk);
      #1;

      // Sequencing with load_done tied high.
      do_reset();
      load_done_i = 1'b1;
      first_rst = 0; first_req = 0; req_cnt = 0; first_fetch = 0;
      for (int n = 1; n <= 14; n++) begin
         cycle();
         if (core_rst_no && first_rst == 0) first_rst = n;
         if (load_req_o) begin
            req_cnt++;
            if (first_req == 0) first_req = n;
         end
         if (fetch_enable_o && first_fetch == 0) first_fetch = n;
      end
      check("seq.core_rst_edge", 64'(first_rst), 64'd5);
      check("seq.load_req_edge", 64'(first_req), 64'd7);
      check("seq.load_req_len",  64'(req_cnt),   64'd1);
      check("seq.fetch_edge",    64'(first_fetch), 64'd8);

      // Stray events before RUN are ignored.
      do_reset();
      tests_passed_i[2] = 1'b1;
      repeat (3) cycle();
      clear_ev();
      repeat (F - 1) cycle();
      tests_passed_i[1] = 1'b1;
      tests_failed_i[0] = 1'b1;
      cycle();
      clear_ev();
      repeat (3) cycle();
      load_done_i = 1'b1;
      to_run();
      repeat (20) cycle();
      check("stray.done", 64'(done_o), 64'd0);

      // Simultaneous events on two harts.
      do_reset();
      load_done_i = 1'b1;
      to_run();
      repeat (3) cycle();
      tests_passed_i[2] = 1'b1;
      set_exit(1, 32'd7);
      cycle();
      clear_ev();
      check("simul.done",   64'(done_o),        64'd1);
      check("simul.status", 64'(status_o),      64'd4);
      check("simul.hart",   64'(done_hart_o),   64'd1);
      check("simul.code",   64'(exit_code_o),   64'd7);
      check("simul.fetch",  64'(fetch_enable_o), 64'd0);
      repeat (4) cycle();

      // Failed beats passed on one hart; later events are ignored.
      do_reset();
      load_done_i = 1'b1;
      to_run();
      tests_failed_i[0] = 1'b1;
      tests_passed_i[0] = 1'b1;
      cycle();
      clear_ev();
      check("prio.status", 64'(status_o),    64'd2);
      check("prio.hart",   64'(done_hart_o), 64'd0);
      check("prio.code",   64'(exit_code_o), 64'd0);
      tests_passed_i[0] = 1'b1;
      cycle();
      clear_ev();
      repeat (3) cycle();
      check("prio.hold", 64'(status_o), 64'd2);

      // Watchdog at 10 cycles, then attempts to disturb DONE.
      do_reset();
      load_done_i = 1'b1;
      max_cycles_i = 32'd10;
      to_run();
      for (int n = 0; n < 30 && !done_o; n++) cycle();
      check("wd.done",   64'(done_o),      64'd1);
      check("wd.status", 64'(status_o),    64'd5);
      check("wd.cycles", 64'(cycle_cnt_o), 64'd10);
      check("wd.hart",   64'(done_hart_o), 64'd0);
      max_cycles_i = 32'd3;
      tests_failed_i = 4'b1111;
      repeat (5) cycle();
      clear_ev();
      check("wd.frozen", 64'(cycle_cnt_o), 64'd10);

      // Watchdog disabled.
      do_reset();
      load_done_i = 1'b1;
      max_cycles_i = '0;
      to_run();
      repeat (1000) cycle();
      check("nowd.done",   64'(done_o),      64'd0);
      check("nowd.cycles", 64'(cycle_cnt_o), 64'd1000);

      // Hart event ties with the watchdog firing.
      do_reset();
      load_done_i = 1'b1;
      max_cycles_i = 32'd6;
      to_run();
      repeat (6) cycle();
      set_exit(3, 32'd0);
      cycle();
      clear_ev();
      check("tie.status", 64'(status_o),    64'd3);
      check("tie.hart",   64'(done_hart_o), 64'd3);
      check("tie.cycles", 64'(cycle_cnt_o), 64'd6);

      // Reset from DONE clears everything immediately.
      do_reset();
      check("rst.done",   64'(done_o),   64'd0);
      check("rst.status", 64'(status_o), 64'd0);

      // Randomized episodes, including stray events and live max_cycles changes.
      for (int e = 0; e < 10; e++) begin
         do_reset();
         max_cycles_i = ($urandom_range(0, 2) == 0) ? '0 : CW'($urandom_range(2, 40));
         ld_delay = $urandom_range(0, 6);
         for (int n = 0; n < 40 && !m_run; n++) begin
            load_done_i = (k >= F + 1 + ld_delay);
            if ($urandom_range(0, 3) == 0) rand_ev(); else clear_ev();
            cycle();
         end
         check("rnd.run_entry", 64'(fetch_enable_o), 64'd1);
         for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 11) == 0) rand_ev(); else clear_ev();
            if ($urandom_range(0, 19) == 0) max_cycles_i = CW'($urandom_range(0, 50));
            cycle();
         end
         clear_ev();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
